// File: rtl/rtype_issue_wb_pkg.sv
// Shared types and decode helper for the R-type issue/writeback front end.
// Holds opcode constants, FSM states and the decoded-instruction record.
package rtype_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OPC_OP  = 5'b01100;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic       legal;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } dec_t;

  // Only the alternate-funct7 forms SUB and SRA are legal alongside the base group.
  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    d.rd     = instr[11:7];
    d.funct3 = instr[14:12];
    d.rs1    = instr[19:15];
    d.rs2    = instr[24:20];
    d.funct7 = instr[31:25];
    d.legal  = (instr[1:0] == 2'b11) && (instr[6:2] == OPC_OP) &&
               ((d.funct7 == F7_BASE) ||
                ((d.funct7 == F7_ALT) && ((d.funct3 == 3'b000) || (d.funct3 == 3'b101))));
    return d;
  endfunction

endpackage

// File: rtl/rtype_issue_wb_if.sv
// Instruction-delivery handshake between the fetch side and the issue block.
interface rtype_issue_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;

  modport master (output in_valid, output in_instr, input in_ready);
  modport slave  (input in_valid, input in_instr, output in_ready);
endinterface

// File: rtl/rtype_issue_wb_regfile.sv
// 32x32 integer register file: two operand reads, one debug read,
// writeback and debug writes (writeback wins on the same index), x0 fixed at 0.
module rtype_regfile
  import rtype_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            dbg_we,
  input  logic [XLEN-1:0] dbg_wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wb_we && (wb_addr == 5'(i)))
          regs[i] <= wb_data;
        else if (dbg_we && (dbg_addr == 5'(i)))
          regs[i] <= dbg_wdata;
      end
    end
  end

  assign rs1_data  = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data  = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];
  assign dbg_rdata = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/rtype_issue_wb.sv
// Issue/writeback wrapper around a registered R-type ALU: decode, register
// file, read bypass and ALU-input forwarding for one instruction per cycle.
module rtype_issue_wb
  import rtype_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  rtype_issue_wb_if.slave   fe,
  output logic [4:0]        alu_opcode,
  output logic [2:0]        alu_funct3,
  output logic [6:0]        alu_funct7,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  input  logic [XLEN-1:0]   alu_out,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              illegal,
  output logic              halted,
  output logic [31:0]       retired,
  input  logic              dbg_we,
  input  logic [4:0]        dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  output logic [XLEN-1:0]   dbg_rdata
);

  state_t state, state_nxt;
  dec_t   dec;
  logic   accept, issue, bad_instr;
  logic [XLEN-1:0] rf_rs1, rf_rs2, rs1_val, rs2_val;

  logic            iss_vld_p0, illegal_p0;
  logic [4:0]      iss_rd_p0, iss_rs1_p0, iss_rs2_p0;
  logic [2:0]      iss_f3_p0;
  logic [6:0]      iss_f7_p0;
  logic [XLEN-1:0] iss_a_p0, iss_b_p0;
  logic            wb_vld_p1;
  logic [4:0]      wb_rd_p1;
  logic            fwd1, fwd2, wb_hit;
  logic [31:0]     retired_cnt;

  assign dec         = decode(fe.in_instr);
  assign fe.in_ready = (state == RUN) && !rst;
  assign accept      = fe.in_valid && fe.in_ready;
  assign issue       = accept && dec.legal;
  assign bad_instr   = accept && !dec.legal;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if ((state == RUN) && bad_instr) state_nxt = HALT;
  end

  rtype_regfile u_rf (
    .clk       (clk),
    .rst       (rst),
    .rs1_addr  (dec.rs1),
    .rs2_addr  (dec.rs2),
    .rs1_data  (rf_rs1),
    .rs2_data  (rf_rs2),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata),
    .wb_we     (wb_vld_p1),
    .wb_addr   (wb_rd_p1),
    .wb_data   (alu_out),
    .dbg_we    (dbg_we),
    .dbg_wdata (dbg_wdata)
  );

  // Decode / read: the retiring result is not in the file until this edge.
  assign wb_hit  = wb_vld_p1 && (wb_rd_p1 != 5'd0);
  assign rs1_val = (wb_hit && (wb_rd_p1 == dec.rs1)) ? alu_out : rf_rs1;
  assign rs2_val = (wb_hit && (wb_rd_p1 == dec.rs2)) ? alu_out : rf_rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld_p0 <= 1'b0;
      iss_rd_p0  <= '0;
      illegal_p0 <= 1'b0;
    end else begin
      iss_vld_p0 <= issue;
      iss_rd_p0  <= issue ? dec.rd : 5'd0;
      illegal_p0 <= bad_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      iss_rs1_p0 <= dec.rs1;
      iss_rs2_p0 <= dec.rs2;
      iss_f3_p0  <= dec.funct3;
      iss_f7_p0  <= dec.funct7;
      iss_a_p0   <= rs1_val;
      iss_b_p0   <= rs2_val;
    end
  end

  // Issue: distance-1 producers are still in the ALU output register.
  assign fwd1 = wb_hit && (wb_rd_p1 == iss_rs1_p0);
  assign fwd2 = wb_hit && (wb_rd_p1 == iss_rs2_p0);

  assign alu_opcode = iss_vld_p0 ? OPC_OP    : 5'd0;
  assign alu_funct3 = iss_vld_p0 ? iss_f3_p0 : 3'd0;
  assign alu_funct7 = iss_vld_p0 ? iss_f7_p0 : 7'd0;
  assign alu_in1    = !iss_vld_p0 ? '0 : (fwd1 ? alu_out : iss_a_p0);
  assign alu_in2    = !iss_vld_p0 ? '0 : (fwd2 ? alu_out : iss_b_p0);

  // Writeback: tracks the ALU's own output register one cycle behind issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_vld_p1   <= 1'b0;
      wb_rd_p1    <= '0;
      retired_cnt <= '0;
    end else begin
      wb_vld_p1 <= iss_vld_p0;
      wb_rd_p1  <= iss_rd_p0;
      if (wb_vld_p1) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign wb_valid = wb_vld_p1;
  assign wb_rd    = wb_rd_p1;
  assign wb_data  = alu_out;
  assign illegal  = illegal_p0;
  assign halted   = (state == HALT);
  assign retired  = retired_cnt;

endmodule

// File: tb/tb_rtype_issue_wb.sv
// Directed bench for rtype_issue_wb with a registered ALU model and an
// architectural register model feeding a writeback scoreboard.
module tb_rtype_issue_wb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  rtype_issue_wb_if fe_if();

  logic [4:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal, halted;
  logic [31:0] retired;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;

  rtype_issue_wb dut (
    .clk        (clk),
    .rst        (rst),
    .fe         (fe_if),
    .alu_opcode (alu_opcode),
    .alu_funct3 (alu_funct3),
    .alu_funct7 (alu_funct7),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_out    (alu_out),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .illegal    (illegal),
    .halted     (halted),
    .retired    (retired),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_rdata  (dbg_rdata)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          n_ret = 0;

  function automatic logic [31:0] alu_f(input logic [4:0] opc, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic [31:0] a,
                                        input logic [31:0] b);
    if (opc != 5'b01100) return 32'd0;
    case (f3)
      3'd0: return f7[5] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, $signed(a) < $signed(b)};
      3'd3: return {31'd0, a < b};
      3'd4: return a ^ b;
      3'd5: return f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Registered ALU stand-in driven by the DUT's issue outputs.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    alu_out <= alu_f(alu_opcode, alu_funct3, alu_funct7, alu_in1, alu_in2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      check("wb_late", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_cycle", cyc, e.cyc);
        check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic send(input logic [31:0] instr, input bit expect_ret);
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] r;
    rd  = instr[11:7];
    rs1 = instr[19:15];
    rs2 = instr[24:20];
    fe_if.in_valid = 1'b1;
    fe_if.in_instr = instr;
    if (expect_ret) begin
      r = alu_f(instr[6:2], instr[14:12], instr[31:25], mregs[rs1], mregs[rs2]);
      if (rd != 5'd0) mregs[rd] = r;
      sb.push_back('{rd, r, cyc + 2});
      n_ret++;
    end
    @(posedge clk); #1;
    fe_if.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    if (a != 5'd0) mregs[a] = d;
  endtask

  task automatic dbg_chk(input logic [4:0] a, input string tag);
    dbg_addr = a;
    #1;
    check(tag, dbg_rdata, mregs[a]);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    fe_if.in_valid = 1'b0;
    fe_if.in_instr = 32'd0;
    dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, fe_if.in_ready}, 32'd0);
    check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_alu_in1", alu_in1, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("run_in_ready", {31'd0, fe_if.in_ready}, 32'd1);

    // basic ADD
    dbg_wr(5'd1, 32'd7);
    dbg_wr(5'd2, 32'd5);
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1'b1);
    idle(3);
    dbg_chk(5'd3, "x3_add");
    check("retired_1", retired, 32'(n_ret));

    // distance-1 forwarding
    send(enc(7'h20, 5'd2, 5'd1, 3'd0, 5'd4), 1'b1);
    check("in_ready_b2b", {31'd0, fe_if.in_ready}, 32'd1);
    send(enc(7'h00, 5'd4, 5'd4, 3'd0, 5'd5), 1'b1);
    idle(3);
    dbg_chk(5'd5, "x5_fwd");

    // distance-2 read bypass
    send(enc(7'h00, 5'd1, 5'd1, 3'd0, 5'd6), 1'b1);
    send(enc(7'h00, 5'd0, 5'd0, 3'd6, 5'd0), 1'b1);
    send(enc(7'h00, 5'd2, 5'd6, 3'd4, 5'd7), 1'b1);
    idle(3);
    dbg_chk(5'd6, "x6_add");
    dbg_chk(5'd7, "x7_bypass");

    // rd = 0 retires without write and is never forwarded
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 1'b1);
    send(enc(7'h00, 5'd1, 5'd0, 3'd0, 5'd8), 1'b1);
    idle(3);
    dbg_chk(5'd0, "x0_zero");
    dbg_chk(5'd8, "x8_no_fwd_x0");

    // shifts/compares on a negative operand
    dbg_wr(5'd10, 32'h8000_0000);
    send(enc(7'h20, 5'd2, 5'd10, 3'd5, 5'd11), 1'b1);
    send(enc(7'h00, 5'd1, 5'd2, 3'd3, 5'd15), 1'b1);
    send(enc(7'h00, 5'd10, 5'd1, 3'd2, 5'd16), 1'b1);
    send(enc(7'h00, 5'd1, 5'd11, 3'd7, 5'd17), 1'b1);
    idle(3);
    dbg_chk(5'd11, "x11_sra");
    dbg_chk(5'd16, "x16_slt");

    // debug write colliding with writeback on the same register
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd12), 1'b1);
    idle(1);
    dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dbg_we = 1'b0;
    idle(2);
    dbg_chk(5'd12, "x12_wb_priority");
    check("retired_mid", retired, 32'(n_ret));

    // illegal instruction halts; older ADD still retires
    send(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd13), 1'b1);
    send(32'h0000_0013, 1'b0);
    @(negedge clk);
    check("ill_pulse", {31'd0, illegal}, 32'd1);
    check("ill_halted", {31'd0, halted}, 32'd1);
    check("ill_in_ready", {31'd0, fe_if.in_ready}, 32'd0);
    check("ill_bubble_opc", {27'd0, alu_opcode}, 32'd0);
    @(posedge clk); #1;
    fe_if.in_valid = 1'b1;
    fe_if.in_instr = enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd9);
    @(negedge clk);
    check("ill_pulse_end", {31'd0, illegal}, 32'd0);
    check("halt_hold", {31'd0, halted}, 32'd1);
    check("halt_in_ready", {31'd0, fe_if.in_ready}, 32'd0);
    idle(3);
    fe_if.in_valid = 1'b0;
    dbg_chk(5'd13, "x13_pre_illegal");
    dbg_chk(5'd9, "x9_not_written");
    check("retired_after_ill", retired, 32'(n_ret));

    // leave HALT, then reset one cycle after an accept
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    n_ret = 0;
    check("rst_exit_halt", {31'd0, halted}, 32'd0);
    dbg_wr(5'd1, 32'd3);
    send(enc(7'h00, 5'd1, 5'd1, 3'd0, 5'd14), 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    @(negedge clk);
    check("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
    idle(3);
    check("rst_mid_retired", retired, 32'd0);
    check("rst_mid_halted", {31'd0, halted}, 32'd0);
    check("rst_mid_illegal", {31'd0, illegal}, 32'd0);
    check("rst_mid_wb_rd", {27'd0, wb_rd}, 32'd0);
    check("rst_mid_in_ready", {31'd0, fe_if.in_ready}, 32'd1);
    for (int i = 0; i < 32; i++) dbg_chk(5'(i), "rst_regs_zero");

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtype_issue_wb.md
# rtype_issue_wb

- Front/back end wrapped around the registered R-type ALU.
- Accepts 32-bit RV32 instruction words over a valid/ready handshake, decodes them, and holds the 32×32 integer register file.
- Drives the ALU's opcode/funct3/funct7/in1/in2 inputs from an issue register, captures the ALU result one cycle later and writes it back.
- Full forwarding gives one instruction per cycle with no stalls; an illegal instruction halts the block.

## Interface
- XLEN, 32, data width (fixed at 32)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  block accepts instruction this cycle
- in_instr  in  32  instruction word
- alu_opcode  out  5  instr[6:2] of issued instruction, 0 on bubble
- alu_funct3  out  3  instr[14:12], 0 on bubble
- alu_funct7  out  7  instr[31:25], 0 on bubble
- alu_in1, alu_in2  out  32  forwarded rs1/rs2 values, 0 on bubble
- alu_out  in  32  registered ALU result
- wb_valid  out  1  retiring instruction this cycle
- wb_rd  out  5  destination of retiring instruction
- wb_data  out  32  equals alu_out when wb_valid
- illegal  out  1  one-cycle pulse on illegal instruction
- halted  out  1  high in HALT state
- retired  out  32  count of wb_valid cycles, wraps at 2^32
- dbg_we  in  1  debug register write
- dbg_addr  in  5  debug read/write index
- dbg_wdata  in  32  debug write data
- dbg_rdata  out  32  combinational read of regs[dbg_addr]; index 0 reads 0

## Operation
- FSM: RUN, HALT.
  - rst → RUN.
  - RUN → HALT on accepting an illegal instruction.
  - HALT exits only on rst.
- in_ready = (state == RUN) && !rst.
- Legal instruction:
  - instr[1:0] = 2'b11 and instr[6:2] = 5'b01100, and
  - funct7 = 0000000 (any funct3), or funct7 = 0100000 with funct3 ∈ {000, 101}.
  - Everything else is illegal.
- Accepted legal instruction loads the issue register:
  - fields: valid, rd, rs1, rs2, funct3, funct7, rs1 value, rs2 value.
  - Register read bypass: if the wb stage is valid, its rd ≠ 0 and equals rs, use alu_out; else use regs[rs]. x0 always reads 0.
- ALU input forwarding, applied while the issue register is valid: if the wb stage is valid with rd ≠ 0 equal to the issue rs1/rs2, alu_in1/alu_in2 = alu_out; else the stored value.
- No valid issue → bubble: all ALU inputs 0, so the ALU yields 0.
- Writeback stage (wb_valid, wb_rd) = issue valid/rd delayed one cycle.
  - regs[wb_rd] ← alu_out at end of cycle when wb_valid && wb_rd ≠ 0.
  - rd = 0 still retires, with no write.
- Illegal instruction:
  - never issued (bubble);
  - illegal pulses the cycle after acceptance; halted asserts the same cycle;
  - older in-flight instructions still complete writeback.
- Debug write: dbg_we writes regs[dbg_addr] (addr ≠ 0). Writeback wins when both target the same register in one cycle.

## Timing
- Accept at end of cycle N → ALU inputs valid in N+1 → alu_out, wb_valid in N+2 → register written at end of N+2.
- Throughput: 1 instruction/cycle.
- Back-to-back dependency (distance 1): covered by ALU-input forwarding.
- Distance 2: covered by read bypass.
- Distance ≥3: covered by the register file.
- Reset values:
  - in_ready 0 during rst;
  - issue valid 0, wb_valid 0, wb_rd 0, illegal 0, halted 0, retired 0;
  - regs all 0.
- rst mid-operation: in-flight instructions discarded, no writeback in the cycle after rst.
- retired increments in the same edge as the register write.

## Structure
- Package rtype_pkg: OPC_OP = 5'b01100, F7_BASE = 7'b0000000, F7_ALT = 7'b0100000, state enum {RUN, HALT}, decoded-instruction struct.
- Sub-module rtype_regfile: 2 combinational read ports, 1 debug read port, writeback and debug write ports with writeback priority, x0 hardwired to 0.

## Test plan
- Debug-write x1=7, x2=5; ADD x3,x1,x2 → wb_valid at N+2 with wb_rd=3, wb_data=12; dbg read x3=12; retired=1.
- SUB x4,x1,x2 then immediately ADD x5,x4,x4 (distance 1) → wb_data 2 then 4, no stall, in_ready stays 1.
- ADD x6,x1,x1; OR x0,x0,x0; XOR x7,x6,x2 (distance 2 via bypass) → x6=14, x7=11.
- ADD x0,x1,x2 → wb_valid=1, wb_rd=0; x0 still reads 0 and is not forwarded to a following ADD x8,x0,x1 (x8=7).
- Legal ADD then 32'h00000013 (ADDI, illegal) → ADD retires; illegal pulses once; halted=1; in_ready=0 until rst; retired unchanged by the illegal word.
- Assert rst in the cycle after an ADD is accepted → no wb_valid follows; all outputs at reset values; regs all 0.
